// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a single-port word memory.
// Supports round-robin or fixed priority, locked read-modify-write and misaligned-access dropping.
module dmem_arbiter #(
    parameter int PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic        m0_lock,
    input  logic        m1_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        owner_r;
    logic        owner_next_s;
    logic        rr_last_r;
    logic        rd_pend_r;
    logic        rd_owner_r;
    logic        err0_r;
    logic        err1_r;

    logic        gnt0_s;
    logic        gnt1_s;
    logic        any_gnt_s;
    logic        sel_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic        sel_we_s;
    logic        sel_lock_s;
    logic        misaligned_s;
    logic        own_req_s;
    logic        own_lock_s;

    // Arbitration: a locked owner excludes the other port; otherwise priority or round-robin on contention.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (state_r == LOCKED) begin
            if (owner_r == 1'b0) begin
                gnt0_s = m0_req;
            end else begin
                gnt1_s = m1_req;
            end
        end else if (m0_req && m1_req) begin
            if ((PRIO_MODE == 1) || rr_last_r) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else begin
            gnt0_s = m0_req;
            gnt1_s = m1_req;
        end
    end

    assign any_gnt_s    = gnt0_s | gnt1_s;
    assign sel_s        = gnt1_s;
    assign sel_addr_s   = sel_s ? m1_addr  : m0_addr;
    assign sel_wdata_s  = sel_s ? m1_wdata : m0_wdata;
    assign sel_we_s     = sel_s ? m1_we    : m0_we;
    assign sel_lock_s   = sel_s ? m1_lock  : m0_lock;
    assign misaligned_s = (sel_addr_s[1:0] != 2'b00);
    assign own_req_s    = owner_r ? m1_req  : m0_req;
    assign own_lock_s   = owner_r ? m1_lock : m0_lock;

    // Memory command from the granted port; misaligned accesses are granted but never reach memory.
    always_comb begin
        mem_addr  = 32'h0000_0000;
        mem_wdata = 32'h0000_0000;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (any_gnt_s) begin
            mem_addr  = sel_addr_s;
            mem_wdata = sel_wdata_s;
            mem_read  = ~sel_we_s & ~misaligned_s;
            mem_write = sel_we_s & ~misaligned_s;
        end else begin
            mem_addr  = 32'h0000_0000;
            mem_wdata = 32'h0000_0000;
        end
    end

    // Lock FSM next state: ownership lasts while the owner keeps requesting with lock set.
    always_comb begin
        state_next_s = state_r;
        owner_next_s = owner_r;
        case (state_r)
            IDLE: begin
                if (any_gnt_s && sel_lock_s) begin
                    state_next_s = LOCKED;
                    owner_next_s = sel_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOCKED: begin
                if (!(own_req_s && own_lock_s)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = LOCKED;
                end
            end
            default: begin
                state_next_s = IDLE;
                owner_next_s = 1'b0;
            end
        endcase
    end

    // State, round-robin pointer, outstanding-load tracking and error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            owner_r    <= 1'b0;
            rr_last_r  <= 1'b1;
            rd_pend_r  <= 1'b0;
            rd_owner_r <= 1'b0;
            err0_r     <= 1'b0;
            err1_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            owner_r    <= owner_next_s;
            if (any_gnt_s) begin
                rr_last_r <= sel_s;
            end
            rd_pend_r  <= mem_read;
            rd_owner_r <= sel_s;
            err0_r     <= gnt0_s & misaligned_s;
            err1_r     <= gnt1_s & misaligned_s;
        end
    end

    assign m0_gnt    = gnt0_s;
    assign m1_gnt    = gnt1_s;
    assign m0_rvalid = rd_pend_r & ~rd_owner_r;
    assign m1_rvalid = rd_pend_r & rd_owner_r;
    assign m0_rdata  = m0_rvalid ? mem_rdata : 32'h0000_0000;
    assign m1_rdata  = m1_rvalid ? mem_rdata : 32'h0000_0000;
    assign m0_err    = err0_r;
    assign m1_err    = err1_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small word-memory model.
// A second instance with fixed priority shares the master inputs.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
    logic        p_m0_gnt, p_m1_gnt, p_m0_rvalid, p_m1_rvalid, p_m0_err, p_m1_err;
    logic [31:0] p_m0_rdata, p_m1_rdata, p_mem_addr, p_mem_wdata;
    logic        p_mem_read, p_mem_write;
    logic [31:0] mem [0:63];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.PRIO_MODE(0)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_lock(m0_lock), .m1_lock(m1_lock), .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_err(m0_err), .m1_err(m1_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.PRIO_MODE(1)) dut_p (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_lock(m0_lock), .m1_lock(m1_lock), .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m0_gnt(p_m0_gnt), .m1_gnt(p_m1_gnt),
        .m0_rvalid(p_m0_rvalid), .m1_rvalid(p_m1_rvalid), .m0_rdata(p_m0_rdata), .m1_rdata(p_m1_rdata),
        .m0_err(p_m0_err), .m1_err(p_m1_err), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
        .mem_read(p_mem_read), .mem_write(p_mem_write), .mem_rdata(mem_rdata)
    );

    // Memory model: word i holds 0xA5000000|i after reset; load data appears one cycle after mem_read.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | i;
            mem_rdata <= 32'h0;
        end else begin
            if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
            if (mem_read) mem_rdata <= mem[mem_addr[7:2]];
        end
    end

    task automatic drive0(input logic r, input logic we, input logic lk, input logic [31:0] a, input logic [31:0] wd);
        m0_req = r; m0_we = we; m0_lock = lk; m0_addr = a; m0_wdata = wd;
    endtask

    task automatic drive1(input logic r, input logic we, input logic lk, input logic [31:0] a, input logic [31:0] wd);
        m1_req = r; m1_we = we; m1_lock = lk; m1_addr = a; m1_wdata = wd;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        drive0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        drive1(1'b1, 1'b1, 1'b0, 32'h24, 32'h55);
        #1;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", {m0_gnt, m1_gnt}); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_mem_rw got=%b exp=00", {mem_read, mem_write}); end
        checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_mem_bus got=%h exp=0", {mem_addr, mem_wdata}); end
        checks++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {m0_rvalid, m1_rvalid, m0_err, m1_err}); end
        checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", {m0_rdata, m1_rdata}); end
        repeat (2) @(negedge clk);
        drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
    endtask

    task automatic test_rr_loads();
        @(negedge clk);
        drive0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        drive1(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        #1;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL rr_c0_gnt got=%b exp=10", {m0_gnt, m1_gnt}); end
        checks++; if (mem_addr !== 32'h10 || mem_read !== 1'b1) begin errors++; $display("FAIL rr_c0_mem got=%h/%b exp=10/1", mem_addr, mem_read); end
        @(negedge clk);
        drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b01 || mem_addr !== 32'h20) begin errors++; $display("FAIL rr_c1_gnt got=%b/%h exp=01/20", {m0_gnt, m1_gnt}, mem_addr); end
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rdata !== 32'hA500_0004) begin errors++; $display("FAIL rr_c1_rvalid got=%b/%h exp=10/a5000004", {m0_rvalid, m1_rvalid}, m0_rdata); end
        @(negedge clk);
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 32'hA500_0008 || m0_rdata !== 32'h0) begin errors++; $display("FAIL rr_c2_rvalid got=%b/%h/%h exp=01/a5000008/0", {m0_rvalid, m1_rvalid}, m1_rdata, m0_rdata); end
    endtask

    task automatic test_lock();
        @(negedge clk);
        drive0(1'b1, 1'b0, 1'b1, 32'h8, 32'h0);
        drive1(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        #1;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL lock_c0_gnt got=%b exp=10", {m0_gnt, m1_gnt}); end
        @(negedge clk);
        drive0(1'b1, 1'b1, 1'b0, 32'h8, 32'h1234_5678);
        #1;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b10 || mem_write !== 1'b1) begin errors++; $display("FAIL lock_c1_gnt got=%b/%b exp=10/1", {m0_gnt, m1_gnt}, mem_write); end
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA500_0002) begin errors++; $display("FAIL lock_c1_rdata got=%b/%h exp=1/a5000002", m0_rvalid, m0_rdata); end
        @(negedge clk);
        drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL lock_c2_gnt got=%b exp=01", {m0_gnt, m1_gnt}); end
        @(negedge clk);
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_store();
        @(negedge clk);
        drive1(1'b1, 1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF);
        #1;
        checks++; if (m1_gnt !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL store_gnt got=%b/%b/%b exp=1/1/0", m1_gnt, mem_write, mem_read); end
        checks++; if (mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h40) begin errors++; $display("FAIL store_bus got=%h/%h exp=deadbeef/40", mem_wdata, mem_addr); end
        @(negedge clk);
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive0(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        #1;
        checks++; if (m0_gnt !== 1'b1 || mem_read !== 1'b1) begin errors++; $display("FAIL store_load_gnt got=%b/%b exp=1/1", m0_gnt, mem_read); end
        @(negedge clk);
        drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_readback got=%b/%h exp=1/deadbeef", m0_rvalid, m0_rdata); end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        drive0(1'b1, 1'b0, 1'b0, 32'h6, 32'h0);
        #1;
        checks++; if (m0_gnt !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL mis_c0 got=%b/%b/%b exp=1/0/0", m0_gnt, mem_read, mem_write); end
        @(negedge clk);
        drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if ({m0_err, m1_err, m0_rvalid} !== 3'b100) begin errors++; $display("FAIL mis_c1 got=%b exp=100", {m0_err, m1_err, m0_rvalid}); end
        @(negedge clk);
        #1;
        checks++; if ({m0_err, m0_rvalid} !== 2'b00) begin errors++; $display("FAIL mis_c2 got=%b exp=00", {m0_err, m0_rvalid}); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_gnt;
        logic [1:0] exp_rv;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 4) begin
                drive0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
                drive1(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
            end else begin
                drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
                drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            #1;
            exp_gnt = (c >= 4) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
            exp_rv  = (c == 0) ? 2'b00 : ((c % 2 == 1) ? 2'b01 : 2'b10);
            checks++; if ({m0_gnt, m1_gnt} !== exp_gnt) begin errors++; $display("FAIL b2b_gnt c=%0d got=%b exp=%b", c, {m0_gnt, m1_gnt}, exp_gnt); end
            checks++; if ({m0_rvalid, m1_rvalid} !== exp_rv) begin errors++; $display("FAIL b2b_rvalid c=%0d got=%b exp=%b", c, {m0_rvalid, m1_rvalid}, exp_rv); end
            if (exp_rv == 2'b10) begin
                checks++; if (m0_rdata !== 32'hA500_0004 || m1_rdata !== 32'h0) begin errors++; $display("FAIL b2b_rdata0 c=%0d got=%h/%h exp=a5000004/0", c, m0_rdata, m1_rdata); end
            end else if (exp_rv == 2'b01) begin
                checks++; if (m1_rdata !== 32'hA500_0008 || m0_rdata !== 32'h0) begin errors++; $display("FAIL b2b_rdata1 c=%0d got=%h/%h exp=a5000008/0", c, m1_rdata, m0_rdata); end
            end
        end
    endtask

    task automatic test_prio();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
            drive1(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
            #1;
            checks++; if ({p_m0_gnt, p_m1_gnt} !== 2'b10) begin errors++; $display("FAIL prio_gnt c=%0d got=%b exp=10", c, {p_m0_gnt, p_m1_gnt}); end
        end
        @(negedge clk);
        drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        drive0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        #1;
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL rst_fl_gnt got=%b exp=1", m0_gnt); end
        @(negedge clk);
        drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_fl_rvalid got=%b exp=00", {m0_rvalid, m1_rvalid}); end
        @(negedge clk);
        reset = 1'b0;
        drive0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        drive1(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        #1;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL rst_first_gnt got=%b exp=10", {m0_gnt, m1_gnt}); end
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_no_rvalid got=%b exp=00", {m0_rvalid, m1_rvalid}); end
        @(negedge clk);
        drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_rr_loads();
        test_lock();
        test_store();
        test_misaligned();
        test_back_to_back();
        test_prio();
        test_reset_inflight();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
